// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

   // Arbiter ownership states.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int unsigned DEF_NUM_REQ        = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

   // Hold-watchdog counter width; covers the full TIMEOUT_CYCLES range.
   localparam int unsigned CNT_W = 16;

   // Index following idx, wrapping back to 0 after n-1.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// ptr, searching upward with wrap. Holds no state.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   idx
);

   logic              found;
   int unsigned       cand;
   logic [IDX_W-1:0]  cand_idx;

   // Scan requesters in priority order starting at ptr.
   always_comb begin
      pick     = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand     = (32'(ptr) + off) % NUM_REQ;
         cand_idx = cand[IDX_W-1:0];
         if (!found && req[cand_idx]) begin
            found          = 1'b1;
            pick[cand_idx] = 1'b1;
            idx            = cand_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level arbiter sharing one UART transmitter among NUM_REQ byte
// requesters. A granted requester owns the transmitter until the byte
// flagged req_last is accepted.
// Optional: define UART_TX_ARB_TIMEOUT_EN to build in a hold watchdog that
// force-releases an owner idle for TIMEOUT_CYCLES and pulses timeout_err.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_vld,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_rdy,
   output logic                 tx_vld,
   output logic [7:0]           tx_data,
   input  logic                 tx_rdy,
   output logic [NUM_REQ-1:0]   grant,
`ifdef UART_TX_ARB_TIMEOUT_EN
   output logic                 timeout_err,
`endif
   output logic                 busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               locked;
   logic               own_vld;
   logic               own_last;
   logic               xfer;
   logic [IDX_W-1:0]   owner_nxt;
   logic               tmo_hit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req  (req_vld),
      .ptr  (ptr_q),
      .pick (pick_oh),
      .idx  (pick_idx)
   );

   assign locked    = (state_q == LOCKED);
   assign own_vld   = req_vld[owner_q];
   assign own_last  = req_last[owner_q];
   assign xfer      = locked & own_vld & tx_rdy;
   assign owner_nxt = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));

   assign busy    = locked;
   assign grant   = grant_q;
   assign tx_vld  = locked & own_vld;
   // Always a defined mux output, even when tx_vld is low.
   assign tx_data = req_data[8*owner_q +: 8];

   // Only the owner sees the transmitter's ready.
   always_comb begin
      req_rdy = '0;
      if (locked) begin
         req_rdy[owner_q] = tx_rdy;
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;

   // Fires on the TIMEOUT_CYCLES-th consecutive stalled-by-owner cycle.
   assign tmo_hit     = locked & ~own_vld & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = terr_q;

   // Watchdog: count owner-idle cycles, clear on transfers and in IDLE.
   always_comb begin
      cnt_d  = cnt_q;
      terr_d = tmo_hit;
      if (!locked || xfer) begin
         cnt_d = '0;
      end else if (!own_vld) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= terr_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state: grant on any request in IDLE, release on last byte or watchdog.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (|req_vld) begin
               state_d = LOCKED;
               owner_d = pick_idx;
               grant_d = pick_oh;
            end
         end
         LOCKED: begin
            if ((xfer && own_last) || tmo_hit) begin
               state_d = IDLE;
               ptr_d   = owner_nxt;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized packet traffic,
// checked every cycle against a packet-level ownership model.
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_vld, req_last, req_rdy, grant;
   logic [31:0]  req_data;
   logic         tx_vld, tx_rdy, busy;
   logic [7:0]   tx_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
   logic         timeout_err;
`endif

   uart_tx_arb #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_vld     (req_vld),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_rdy     (req_rdy),
      .tx_vld      (tx_vld),
      .tx_data     (tx_data),
      .tx_rdy      (tx_rdy),
      .grant       (grant),
`ifdef UART_TX_ARB_TIMEOUT_EN
      .timeout_err (timeout_err),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Per-requester packet queues: bit 8 marks the last byte of a packet.
   logic [8:0]  pq[4][$];
   logic [3:0]  allow;

   // Reference model: current owner (-1 = none), round-robin pointer.
   int          m_owner;
   int          m_ptr;
   int          m_cnt;
   bit          m_terr;

   // Observations of the DUT.
   logic [11:0] obs_xfer[$];
   logic [3:0]  obs_grants[$];
   int          obs_gaps[$];
   logic [3:0]  prev_grant;
   int          idle_run;
   int          n_terr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      obs_xfer.delete();
      obs_grants.delete();
      obs_gaps.delete();
      prev_grant = '0;
      idle_run   = 0;
      n_terr     = 0;
   endtask

   task automatic drive();
      for (int r = 0; r < N; r++) begin
         if (pq[r].size() > 0 && allow[r]) begin
            req_vld[r]          = 1'b1;
            req_data[r*8 +: 8]  = pq[r][0][7:0];
            req_last[r]         = pq[r][0][8];
         end else begin
            req_vld[r]          = 1'b0;
            req_data[r*8 +: 8]  = 8'($urandom);
            req_last[r]         = 1'($urandom);
         end
      end
   endtask

   task automatic check_outputs();
      logic [3:0] eg;
      logic       etv;
      eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      etv = (m_owner >= 0) ? req_vld[m_owner] : 1'b0;
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("tx_vld", 32'(tx_vld), 32'(etv));
      chk("req_rdy", 32'(req_rdy), 32'(tx_rdy ? eg : 4'b0000));
      if (etv) chk("tx_data", 32'(tx_data), 32'(req_data[m_owner*8 +: 8]));
`ifdef UART_TX_ARB_TIMEOUT_EN
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
`endif
   endtask

   task automatic monitor();
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
         obs_grants.push_back(grant);
         obs_gaps.push_back(idle_run);
      end
      idle_run   = (grant == 4'b0000) ? idle_run + 1 : 0;
      prev_grant = grant;
      if (tx_vld && tx_rdy) obs_xfer.push_back({grant, tx_data});
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (timeout_err) n_terr++;
`endif
   endtask

   task automatic model_update();
      bit found;
      int c, o;
      m_terr = 1'b0;
      if (m_owner < 0) begin
         m_cnt = 0;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && req_vld[c]) begin
               found   = 1'b1;
               m_owner = c;
            end
         end
      end else begin
         o = m_owner;
         if (req_vld[o] && tx_rdy) begin
            void'(pq[o].pop_front());
            m_cnt = 0;
            if (req_last[o]) begin
               m_owner = -1;
               m_ptr   = (o + 1) % N;
            end
         end else if (!req_vld[o]) begin
            m_cnt++;
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (m_cnt >= TO) begin
               m_owner = -1;
               m_ptr   = (o + 1) % N;
               m_terr  = 1'b1;
               m_cnt   = 0;
            end
`endif
         end
      end
   endtask

   // One clock: drive, sample on the falling edge, advance the model on the rising edge.
   task automatic cycle();
      drive();
      @(negedge clk);
      check_outputs();
      monitor();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic model_reset();
      for (int r = 0; r < N; r++) pq[r].delete();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_terr  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      allow    = 4'b1111;
      tx_rdy   = 1'b1;
      req_vld  = '0;
      req_last = '0;
      req_data = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_tx_vld", 32'(tx_vld), 32'h0);
      chk("rst_req_rdy", 32'(req_rdy), 32'h0);
`ifdef UART_TX_ARB_TIMEOUT_EN
      chk("rst_timeout_err", 32'(timeout_err), 32'h0);
`endif
      rst_n = 1'b1;
      clear_obs();
   endtask

   initial begin
      // Single requester, two-byte packet, then pointer moves to 1.
      do_reset();
      pq[0].push_back(9'h055);
      pq[0].push_back(9'h1A3);
      run(4);
      chk("single_grant", 32'(obs_grants[0]), 32'h1);
      chk("single_latency", 32'(obs_gaps[0]), 32'd1);
      chk("single_nxfer", 32'(obs_xfer.size()), 32'd2);
      chk("single_b0", 32'(obs_xfer[0]), 32'h155);
      chk("single_b1", 32'(obs_xfer[1]), 32'h1A3);
      chk("single_idle", 32'(busy), 32'h0);
      pq[0].push_back(9'h111);
      pq[1].push_back(9'h122);
      run(3);
      chk("single_ptr1", 32'(obs_grants[1]), 32'h2);

      // Round-robin among 0, 2, 3 with one-byte packets.
      do_reset();
      pq[0].push_back(9'h111);
      pq[0].push_back(9'h112);
      pq[2].push_back(9'h121);
      pq[3].push_back(9'h131);
      run(9);
      chk("rr_count", 32'(obs_grants.size()), 32'd4);
      chk("rr_g0", 32'(obs_grants[0]), 32'h1);
      chk("rr_g1", 32'(obs_grants[1]), 32'h4);
      chk("rr_g2", 32'(obs_grants[2]), 32'h8);
      chk("rr_g3", 32'(obs_grants[3]), 32'h1);
      for (int i = 1; i < 4; i++) chk("rr_gap", 32'(obs_gaps[i]), 32'd1);

      // Backpressure: owner 1 holds its byte while tx_rdy is low.
      do_reset();
      pq[1].push_back(9'h17E);
      tx_rdy = 1'b0;
      run(21);
      chk("bp_noxfer", 32'(obs_xfer.size()), 32'd0);
      chk("bp_hold_vld", 32'(tx_vld), 32'h1);
      chk("bp_hold_data", 32'(tx_data), 32'h7E);
      tx_rdy = 1'b1;
      run(2);
      chk("bp_xfer", 32'(obs_xfer[0]), 32'h27E);

      // No preemption: requester 0 waits for owner 2 to finish its packet.
      do_reset();
      pq[2].push_back(9'h0C1);
      pq[2].push_back(9'h0C2);
      pq[2].push_back(9'h1C3);
      run(2);
      pq[0].push_back(9'h1D0);
      run(6);
      chk("np_g0", 32'(obs_grants[0]), 32'h4);
      chk("np_g1", 32'(obs_grants[1]), 32'h1);
      chk("np_x0", 32'(obs_xfer[0]), 32'h4C1);
      chk("np_x1", 32'(obs_xfer[1]), 32'h4C2);
      chk("np_x2", 32'(obs_xfer[2]), 32'h4C3);
      chk("np_x3", 32'(obs_xfer[3]), 32'h1D0);

      // Asynchronous reset in the middle of a packet.
      do_reset();
      pq[1].push_back(9'h0B1);
      pq[1].push_back(9'h0B2);
      pq[1].push_back(9'h1B3);
      run(3);
      chk("ar_pre_busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_grant", 32'(grant), 32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      chk("ar_tx_vld", 32'(tx_vld), 32'h0);
      chk("ar_req_rdy", 32'(req_rdy), 32'h0);
      rst_n = 1'b1;
      model_reset();
      clear_obs();
      pq[3].push_back(9'h1E3);
      pq[0].push_back(9'h1E0);
      run(4);
      chk("ar_ptr0", 32'(obs_grants[0]), 32'h1);
      chk("ar_first", 32'(obs_xfer[0]), 32'h1E0);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Watchdog: owner 3 stalls after one non-last byte.
      do_reset();
      pq[3].push_back(9'h033);
      pq[3].push_back(9'h134);
      allow = 4'b1000;
      run(2);
      allow = 4'b0000;
      run(17);
      chk("to_pulse", 32'(n_terr), 32'd1);
      chk("to_released", 32'(grant), 32'h0);
      allow = 4'b1001;
      pq[0].push_back(9'h1A0);
      run(3);
      chk("to_ptr0", 32'(obs_grants[1]), 32'h1);
      chk("to_pulse_once", 32'(n_terr), 32'd1);
`endif

      // Randomized packet traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int r = 0; r < N; r++) begin
            if (pq[r].size() < 3 && ($urandom % 4) == 0) begin
               int len;
               len = 1 + int'($urandom % 4);
               for (int b = 0; b < len; b++) pq[r].push_back({b == len - 1, 8'($urandom)});
            end
         end
         allow  = 4'($urandom) | 4'($urandom);
         tx_rdy = ($urandom % 4) != 0;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
